// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// segment-off pattern and a constant clog2 used to size counters.
package ss_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g..a}; entry 15 (F) first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ss_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ss_hex_decoder
    import ss_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/ss_scan_drive.sv
// Self-timed multiplexed common-anode seven-segment driver, double-buffered.
// Define SS_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module ss_scan_drive
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    update_pending,
    output logic                    frame_tick
);

    localparam int IDX_W   = clog2(NUM_DIGITS);
    localparam int PRESC_W = clog2(REFRESH_DIV);

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_stg_data, r_act_data;
    logic [NUM_DIGITS-1:0]   r_stg_dp, r_stg_blank, r_act_dp, r_act_blank;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    logic                    w_slot_end, w_frame_end, w_guard, w_blank;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg_dec;
    logic [NUM_DIGITS-1:0]   w_an_on, w_lz;

    assign w_slot_end  = (r_presc == PRESC_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_guard     = (r_presc < PRESC_W'(GUARD));
    assign w_an_on     = ~(NUM_DIGITS'(1) << r_idx);
    assign w_nib       = r_act_data[{r_idx, 2'b00} +: 4];

    ss_hex_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_dec)
    );

`ifdef SS_LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // Walk down from the top digit; a digit is dark while everything above
    // and including it is a zero nibble with no DP. Digit 0 always shows.
    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (r_act_data[4*k +: 4] == 4'h0) && !r_act_dp[k];
            w_lz[k]    = w_zero_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_blank = r_act_blank[r_idx] | w_lz[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_stg_data   <= '0;
            r_stg_dp     <= '0;
            r_stg_blank  <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pending    <= 1'b0;
            r_seg        <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= w_frame_end ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_frame_tick <= w_frame_end;

            if (load) begin
                r_stg_data  <= data_in;
                r_stg_dp    <= dp_in;
                r_stg_blank <= blank_in;
            end

            // A load coinciding with the frame boundary bypasses staging.
            if (w_frame_end && load) begin
                r_act_data  <= data_in;
                r_act_dp    <= dp_in;
                r_act_blank <= blank_in;
                r_pending   <= 1'b0;
            end else if (w_frame_end && r_pending) begin
                r_act_data  <= r_stg_data;
                r_act_dp    <= r_stg_dp;
                r_act_blank <= r_stg_blank;
                r_pending   <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            r_an   <= w_guard ? '1 : w_an_on;
            r_seg  <= w_blank ? SEG_OFF : w_seg_dec;
            r_dp_n <= w_blank | ~r_act_dp[r_idx];
        end
    end

    assign seg            = r_seg;
    assign dp_n           = r_dp_n;
    assign an             = r_an;
    assign update_pending = r_pending;
    assign frame_tick     = r_frame_tick;

endmodule

// File: tb/tb_ss_scan_drive.sv
// Bench for ss_scan_drive (4 digits, 8-cycle slots, 2-cycle guard): per-cycle
// reference model, frame-level vector table and multi-cycle corner sequences.
module tb_ss_scan_drive;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int G  = 2;
    localparam int FR = N * R;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        update_pending;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference state: t counts cycles since reset, so slot and digit
    // follow from plain division of the elapsed time.
    int          t = 0;
    logic [15:0] m_sd = '0, m_ad = '0;
    logic [3:0]  m_sp = '0, m_sb = '0, m_ap = '0, m_ab = '0;
    logic        m_pend = 1'b0;
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic [3:0]  e_an;
    logic        e_ft;
    logic [6:0]  HEX [16];
    vec_t        vecs [7];

    always #5 clk = ~clk;

    ss_scan_drive #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD(G)) dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .data_in        (data_in),
        .dp_in          (dp_in),
        .blank_in       (blank_in),
        .seg            (seg),
        .dp_n           (dp_n),
        .an             (an),
        .update_pending (update_pending),
        .frame_tick     (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_edge();
        int   p, d;
        logic bl, fe;
        if (rst) begin
            t = 0;
            m_sd = '0; m_sp = '0; m_sb = '0;
            m_ad = '0; m_ap = '0; m_ab = '0;
            m_pend = 1'b0;
            e_seg = 7'h7F; e_dpn = 1'b1; e_an = 4'hF; e_ft = 1'b0;
        end else begin
            p  = t % R;
            d  = (t / R) % N;
            fe = ((t % FR) == FR - 1);
            e_an = (p < G) ? 4'hF : ~(4'(1) << d);
            bl = m_ab[d];
`ifdef SS_LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_ad >> (4 * d)) == 16'h0 && (m_ap >> d) == 4'h0) bl = 1'b1;
`endif
            e_seg = bl ? 7'h7F : HEX[m_ad[4*d +: 4]];
            e_dpn = bl ? 1'b1 : ~m_ap[d];
            e_ft  = fe;
            if (load && fe) begin
                m_ad = data_in; m_ap = dp_in; m_ab = blank_in; m_pend = 1'b0;
            end else if (fe && m_pend) begin
                m_ad = m_sd; m_ap = m_sp; m_ab = m_sb; m_pend = 1'b0;
            end else if (load) begin
                m_sd = data_in; m_sp = dp_in; m_sb = blank_in; m_pend = 1'b1;
            end
            t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dpn));
        check("an", 32'(an), 32'(e_an));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        check("update_pending", 32'(update_pending), 32'(m_pend));
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < 2 * FR && (t % FR) != phase; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data_in = d; dp_in = p; blank_in = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Wait for frame_tick, then sample the middle of each digit slot.
    task automatic scan_check(input string tag, input vec_t v);
        logic       got;
        logic [3:0] an_exp;
        got = 1'b0;
        for (int i = 0; i < 2 * FR && !got; i++) begin
            tick();
            got = frame_tick;
        end
        check({tag, "_sync"}, 32'(got), 32'(1));
        for (int k = 1; k <= FR; k++) begin
            tick();
            if ((k - 1) % R == 4) begin
                int d = (k - 1) / R;
                an_exp = ~(4'(1) << d);
                check({tag, "_seg"}, 32'(seg), 32'(v.seg[d]));
                check({tag, "_dpn"}, 32'(dp_n), 32'(v.dpn[d]));
                check({tag, "_an"}, 32'(an), 32'(an_exp));
            end
        end
    endtask

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                                input logic [3:0][6:0] s, input logic [3:0] dn);
        vec_t v;
        v.data = d; v.dp = p; v.blank = b; v.seg = s; v.dpn = dn;
        return v;
    endfunction

    initial begin
        logic got;
        int   n;

        HEX = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        // seg fields are listed digit 3 first, digit 0 last
        vecs[0] = mk(16'h3A08, 4'b0100, 4'b0000, {7'h30, 7'h08, 7'h40, 7'h00}, 4'b1011);
        vecs[1] = mk(16'hEDBC, 4'b0000, 4'b0000, {7'h06, 7'h21, 7'h03, 7'h46}, 4'b1111);
        vecs[2] = mk(16'h1234, 4'b0001, 4'b0010, {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1110);
        vecs[3] = mk(16'hFFFF, 4'b1111, 4'b0000, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000);
        vecs[4] = mk(16'h0100, 4'b1000, 4'b0000, {7'h40, 7'h79, 7'h40, 7'h40}, 4'b0111);
`ifdef SS_LEADING_ZERO_BLANK_EN
        vecs[5] = mk(16'h0050, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);
        vecs[6] = mk(16'h0000, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
`else
        vecs[5] = mk(16'h0050, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111);
        vecs[6] = mk(16'h0000, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
`endif

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dpn", 32'(dp_n), 32'(1));
        check("rst_an", 32'(an), 32'hF);
        check("rst_pend", 32'(update_pending), 32'(0));
        check("rst_ft", 32'(frame_tick), 32'(0));
        rst = 1'b0;

        // Frame period
        got = 1'b0;
        for (int i = 0; i < 2 * FR && !got; i++) begin tick(); got = frame_tick; end
        n = 0; got = 1'b0;
        for (int i = 0; i < 2 * FR && !got; i++) begin tick(); n++; got = frame_tick; end
        check("ft_period", n, FR);

        // Table: load mid-frame, expect it displayed in the following frame
        for (int i = 0; i < 7; i++) begin
            run_to(12);
            do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
            check($sformatf("vec%0d_pend", i), 32'(update_pending), 32'(1));
            scan_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Load on the frame_end cycle goes straight to active
        run_to(FR - 1);
        do_load(16'h5A3C, 4'b0000, 4'b0000);
        check("fe_load_pend", 32'(update_pending), 32'(0));
        for (int i = 0; i < 4; i++) tick();
        check("fe_load_seg", 32'(seg), 32'h46);
        check("fe_load_an", 32'(an), 32'hE);

        // Two loads in one frame: last wins
        run_to(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run_to(20);
        do_load(16'h2222, 4'b0000, 4'b0000);
        scan_check("two_loads", mk(16'h2222, 4'b0000, 4'b0000, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111));

        // Reset in slot 2 with data pending discards it
        run_to(3);
        do_load(16'h9999, 4'b1111, 4'b0000);
        run_to(2 * R + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_pend", 32'(update_pending), 32'(0));
        for (int i = 0; i < 3; i++) tick();
        check("mid_rst_restart_an", 32'(an), 32'hE);
        scan_check("after_rst", vecs[6]);

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            load     = ($urandom_range(0, 15) == 0);
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 7) == 0) data_in = data_in & 16'h00FF;
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        load = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_scan_drive.md
Name: ss_scan_drive

Overview:
- Parametrised, self-timed multiplexed seven-segment driver for N digits.
- Internal prescaler and digit scanner; no external select input.
- Double-buffered digit/DP/blank registers, so the host updates atomically at frame boundaries.
- Anode dead-time guard suppresses ghosting between digits.
- Sits between the display-formatting logic and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; range 2..16.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- GUARD, 16, cycles at the start of each slot with all anodes off; must satisfy 0 <= GUARD < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures data_in/dp_in/blank_in into the staging register.
- data_in  in  4*NUM_DIGITS  hex nibble per digit; digit k = data_in[4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit k dark (segments and DP off).
- seg  out  7  segments, active low; seg[0]=a ... seg[6]=g.
- dp_n  out  1  decimal point, active low.
- an  out  NUM_DIGITS  anodes, active low; at most one low at a time.
- update_pending  out  1  staging holds data not yet applied.
- frame_tick  out  1  one-cycle pulse after each full scan.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, on rst. All outputs are registered.
- Reset values:
  - seg = 7'h7F, dp_n = 1, an = all ones.
  - frame_tick = 0, update_pending = 0.
  - Prescaler, digit index, staging and active registers all 0.
- Prescaler: presc counts 0..REFRESH_DIV-1.
  - slot_end = (presc == REFRESH_DIV-1). On slot_end, presc <= 0.
  - idx <= idx+1, wrapping from NUM_DIGITS-1 to 0.
- Frame end: frame_end = slot_end && idx == NUM_DIGITS-1. frame_tick = 1 in the cycle after frame_end.
- Load:
  - On load, staging <= {data_in, dp_in, blank_in} and update_pending <= 1.
  - A load while pending overwrites staging; last load wins.
- Apply:
  - On frame_end with update_pending = 1, active <= staging and update_pending <= 0.
  - load and frame_end in the same cycle: inputs go straight to active, and update_pending stays 0.
- Output registers, computed from presc/idx of the current cycle and seen one cycle later:
  - presc < GUARD: an = all ones.
  - Otherwise: an = ~(1 << idx).
  - seg = decode(active nibble[idx]) and dp_n = ~active_dp[idx].
  - active_blank[idx] = 1 forces seg = 7'h7F and dp_n = 1; an still follows the scan.
- Decode, active-low, order {g..a}:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78.
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E.
- Reset mid-frame: on the next edge all state returns to reset values and staged data is discarded. Scanning restarts at digit 0, presc 0.
- Frame period is exactly NUM_DIGITS*REFRESH_DIV cycles. No lost or duplicated slots at wrap.

Optional Feature:
- Macro: SS_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k >= 1) is blanked when its active nibble and every higher digit's nibble are 0, and none of their active DP bits are set.
  - Digit 0 is never auto-blanked.
  - OR-ed with active_blank; derived purely from the active register.
- Undefined: only blank_in controls blanking; zeros display as "0".

Decomposition:
- Package ss_pkg:
  - 16-entry 7-bit active-low hex segment constant table.
  - SEG_OFF = 7'h7F constant.
  - Function clog2 used to size idx.
- Sub-module ss_hex_decoder: purely combinational, 4-bit nibble to 7-bit active-low segments via the table.
- Everything else (prescaler, scanner, double buffer, blanking, output regs) lives in ss_scan_drive.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2):
- Reset, then run 32 cycles: an cycles E,D,B,7 in slots of 6 low cycles preceded by 2 all-ones cycles. frame_tick pulses once every 32 cycles. seg=40 throughout.
- load data_in=16'h3A08, dp_in=4'b0100 mid-frame: display is unchanged and update_pending=1 until frame_end. Next frame shows digits 0..3 as 00, 40, 08, 30 with dp_n=0 only on digit 2.
- load and frame_end in the same cycle: new values are active in the next slot (digit 0), and update_pending never rises.
- Two loads within one frame (16'h1111 then 16'h2222): the next frame shows 2222 (seg=24 on every digit).
- Assert rst for 1 cycle during slot 2 with pending data: next cycle an=F, seg=7F, update_pending=0. Scan restarts at digit 0 and pending data is not applied.
- Leading-zero blank:
  - With SS_LEADING_ZERO_BLANK_EN, data 16'h0050 shows digits 3,2 dark, digit 1 = 12, digit 0 = 40.
  - With SS_LEADING_ZERO_BLANK_EN and data 16'h0000, only digit 0 is lit.
  - Without the macro, data 16'h0050 shows all four digits lit.
